// File: rtl/run_detector_param_if.sv
// Serial-sample bus between a bit source and the run detector.
// The source drives the samples and controls; the detector returns its status.
interface run_detector_param_if #(
    parameter int RUN_W = 2,
    parameter int EVT_W = 8
);
    logic             data_in;
    logic             valid;
    logic             target;
    logic             mealy_mode;
    logic             overlap;
    logic             clear_cnt;
    logic             detect;
    logic [RUN_W-1:0] run_cnt;
    logic [EVT_W-1:0] evt_cnt;
    logic             evt_sat;

    modport master (
        output data_in, valid, target, mealy_mode, overlap, clear_cnt,
        input  detect, run_cnt, evt_cnt, evt_sat
    );

    modport slave (
        input  data_in, valid, target, mealy_mode, overlap, clear_cnt,
        output detect, run_cnt, evt_cnt, evt_sat
    );
endinterface

// File: rtl/run_detector_param.sv
// Detects RUN_LEN consecutive valid samples equal to a runtime target bit,
// with Mealy/Moore output selection, overlap control and a saturating hit counter.
//
// state | meaning
// IDLE  | run_cnt == 0, no matching samples pending
// RUN   | 0 < run_cnt < RUN_LEN-1, partial run in progress
// ARMED | run_cnt == RUN_LEN-1, next matching sample is a hit
module run_detector_param #(
    parameter int RUN_LEN = 3,
    parameter int RUN_W   = 2,
    parameter int EVT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    run_detector_param_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, ARMED} state_t;

    localparam logic [RUN_W-1:0] ARM_CNT = RUN_W'(RUN_LEN - 1);
    localparam logic [EVT_W-1:0] EVT_MAX = '1;

    state_t           state;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic             target_q, target_d;
    logic             detect_q;
    logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;
    logic             evt_sat_q, evt_sat_d;
    logic             match, tchg, hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt_q <= '0;
            target_q  <= 1'b0;
            detect_q  <= 1'b0;
            evt_cnt_q <= '0;
            evt_sat_q <= 1'b0;
        end else begin
            run_cnt_q <= run_cnt_d;
            target_q  <= target_d;
            detect_q  <= hit;
            evt_cnt_q <= evt_cnt_d;
            evt_sat_q <= evt_sat_d;
        end
    end

    // ARMED takes priority so RUN_LEN==1 (run_cnt pinned at 0) is always armed.
    always_comb begin
        state = RUN;
        if (run_cnt_q == ARM_CNT) begin
            state = ARMED;
        end else if (run_cnt_q == '0) begin
            state = IDLE;
        end
    end

    always_comb begin
        match     = bus.valid & (bus.data_in == bus.target);
        tchg      = bus.valid & (bus.target != target_q);
        hit       = (RUN_LEN == 1) ? match : (match & (state == ARMED) & ~tchg);
        run_cnt_d = run_cnt_q;
        target_d  = target_q;
        evt_cnt_d = evt_cnt_q;
        evt_sat_d = evt_sat_q;

        if (bus.valid) begin
            if (tchg) begin
                target_d  = bus.target;
                run_cnt_d = (match && (RUN_LEN > 1)) ? RUN_W'(1) : '0;
            end else if (!match) begin
                run_cnt_d = '0;
            end else if (hit) begin
                run_cnt_d = bus.overlap ? ARM_CNT : '0;
            end else begin
                run_cnt_d = run_cnt_q + RUN_W'(1);
            end
        end

        if (bus.clear_cnt) begin
            evt_cnt_d = '0;
            evt_sat_d = 1'b0;
        end else if (hit && !evt_sat_q) begin
            evt_cnt_d = evt_cnt_q + EVT_W'(1);
            evt_sat_d = (evt_cnt_d == EVT_MAX);
        end
    end

    assign bus.detect  = reset ? 1'b0 : (bus.mealy_mode ? hit : detect_q);
    assign bus.run_cnt = run_cnt_q;
    assign bus.evt_cnt = evt_cnt_q;
    assign bus.evt_sat = evt_sat_q;
endmodule
